// File: rtl/serial_shifter.sv
// Purpose : multi-cycle SLL/SRL/SRA unit that shifts the operand one bit per clock
//           (or four bits per clock while possible when SERIAL_SHIFTER_STEP4_EN is defined).
// Latency : accept edge N -> out_valid in cycle N+1+shamt (N+1 for shamt=0 or reserved type).
// Backpr. : holds DONE with r/out_valid stable while out_ready is low; in_ready only in IDLE.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset; aborts any operation in flight
//   in_valid   request present on a/shamt/op_type
//   in_ready   unit is IDLE and will accept a request
//   a          operand to shift
//   shamt      shift amount, 0..WIDTH-1
//   op_type    shift type: 00 SLL, 01 SRL, 10 SRA, 11 reserved (result 0)
//                (named op_type because "type" is a reserved word in SystemVerilog)
//   out_valid  r holds a completed result
//   out_ready  consumer accepts r
//   r          shifted result (mirrors the working register)
//   busy       high in SHIFT or DONE
//
// Build option: SERIAL_SHIFTER_STEP4_EN -- when defined, each SHIFT cycle moves four
// bit positions while at least four remain, otherwise one. Results are identical.

module serial_shifter #(
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         a,
    input  logic [$clog2(WIDTH)-1:0] shamt,
    input  logic [1:0]               op_type,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         r,
    output logic                     busy
);

    localparam int SW = $clog2(WIDTH);

    localparam logic [1:0] T_SLL = 2'b00;
    localparam logic [1:0] T_SRL = 2'b01;
    localparam logic [1:0] T_SRA = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    state_t            r_state;
    logic [WIDTH-1:0]  r_work;
    logic [SW-1:0]     r_cnt;
    logic [1:0]        r_type;
    logic              r_in_ready;
    logic              r_out_valid;
    logic              r_busy;

    logic [WIDTH-1:0]  w_next_work;
    logic [SW-1:0]     w_next_cnt;

    // One bit position of the selected shift.
    function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v,
                                                   input logic [1:0]       t);
        logic [WIDTH-1:0] res;
        case (t)
            T_SLL:   res = {v[WIDTH-2:0], 1'b0};
            T_SRL:   res = {1'b0, v[WIDTH-1:1]};
            T_SRA:   res = {v[WIDTH-1], v[WIDTH-1:1]};
            default: res = v;
        endcase
        return res;
    endfunction

`ifdef SERIAL_SHIFTER_STEP4_EN
    localparam logic [SW-1:0] C_FOUR = SW'(4);

    // Four bit positions of the selected shift.
    function automatic logic [WIDTH-1:0] shift_four(input logic [WIDTH-1:0] v,
                                                    input logic [1:0]       t);
        logic [WIDTH-1:0] res;
        case (t)
            T_SLL:   res = {v[WIDTH-5:0], 4'b0000};
            T_SRL:   res = {4'b0000, v[WIDTH-1:4]};
            T_SRA:   res = {{4{v[WIDTH-1]}}, v[WIDTH-1:4]};
            default: res = v;
        endcase
        return res;
    endfunction

    // Take the big step while it cannot overshoot, then finish bit by bit.
    always_comb begin
        w_next_work = r_work;
        w_next_cnt  = r_cnt;
        if (r_cnt >= C_FOUR) begin
            w_next_work = shift_four(r_work, r_type);
            w_next_cnt  = r_cnt - C_FOUR;
        end else begin
            w_next_work = shift_one(r_work, r_type);
            w_next_cnt  = r_cnt - SW'(1);
        end
    end
`else
    always_comb begin
        w_next_work = shift_one(r_work, r_type);
        w_next_cnt  = r_cnt - SW'(1);
    end
`endif

    // Handshake flags are registered alongside the state so every output is a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_work      <= '0;
            r_cnt       <= '0;
            r_type      <= T_SLL;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_type     <= op_type;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        if (op_type == 2'b11) begin
                            // Reserved encoding: complete immediately with zero.
                            r_work      <= '0;
                            r_cnt       <= '0;
                            r_state     <= ST_DONE;
                            r_out_valid <= 1'b1;
                        end else if (shamt == '0) begin
                            r_work      <= a;
                            r_cnt       <= '0;
                            r_state     <= ST_DONE;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_work  <= a;
                            r_cnt   <= shamt;
                            r_state <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    r_work <= w_next_work;
                    r_cnt  <= w_next_cnt;
                    if (w_next_cnt == '0) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign r         = r_work;

endmodule

// File: tb/tb_serial_shifter.sv
// Purpose : directed and randomised checks of serial_shifter results, latency and handshake.
// Latency : expected latency follows the build option SERIAL_SHIFTER_STEP4_EN.
// Backpr. : bench holds out_ready low until it chooses to consume a result.

module tb_serial_shifter;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [4:0]  shamt;
    logic [1:0]  op_type;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] r;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_shifter #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .shamt     (shamt),
        .op_type   (op_type),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r         (r),
        .busy      (busy)
    );

    // Move to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_lat(input int sh, input int ty);
        if (ty == 3 || sh == 0) return 1;
`ifdef SERIAL_SHIFTER_STEP4_EN
        return 1 + sh / 4 + sh % 4;
`else
        return 1 + sh;
`endif
    endfunction

    // Issue one request and wait (bounded) for out_valid. Returns -1 latency on timeout.
    // With noisy set, inputs are scrambled and in_valid kept high while the op is in flight.
    task automatic do_op(input logic [31:0] ai, input logic [4:0] si, input logic [1:0] ti,
                         input bit noisy, output int lat, output logic [31:0] res);
        a        = ai;
        shamt    = si;
        op_type  = ti;
        in_valid = 1'b1;
        tick();
        if (!noisy) in_valid = 1'b0;
        lat = -1;
        res = 32'hxxxx_xxxx;
        for (int k = 1; k <= 40; k++) begin
            if (noisy) begin
                a       = $urandom;
                shamt   = 5'($urandom);
                op_type = 2'($urandom);
            end
            if (out_valid === 1'b1) begin
                lat = k;
                res = r;
                break;
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b1;          // reset must win over a simultaneous request
        a        = 32'h1234_5678;
        shamt    = 5'd3;
        op_type  = 2'b00;
        out_ready = 1'b0;
        tick();
        tick();
        checks++; if (in_ready !== 1'b1)  begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (r !== 32'h0)        begin failures++; $display("FAIL reset_r got=%h exp=00000000", r); end
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_no_accept busy got=%b exp=0", busy); end
    endtask

    task automatic test_sll_basic();
        int lat;
        logic [31:0] res;
        do_op(32'h0000_0001, 5'd5, 2'b00, 1'b0, lat, res);
        checks++; if (lat !== exp_lat(5, 0)) begin failures++; $display("FAIL sll5_latency got=%0d exp=%0d", lat, exp_lat(5, 0)); end
        checks++; if (res !== 32'h0000_0020) begin failures++; $display("FAIL sll5_result got=%h exp=00000020", res); end
        checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL sll5_done_flags busy=%b in_ready=%b exp busy=1 in_ready=0", busy, in_ready); end
        consume();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL sll5_after_consume in_ready=%b out_valid=%b busy=%b exp 1/0/0", in_ready, out_valid, busy);
        end
    endtask

    task automatic test_max_shift();
        int lat;
        logic [31:0] res;
        do_op(32'h8000_0000, 5'd31, 2'b10, 1'b0, lat, res);
        checks++; if (lat !== exp_lat(31, 2)) begin failures++; $display("FAIL sra31_latency got=%0d exp=%0d", lat, exp_lat(31, 2)); end
        checks++; if (res !== 32'hFFFF_FFFF) begin failures++; $display("FAIL sra31_result got=%h exp=ffffffff", res); end
        consume();
        do_op(32'h8000_0000, 5'd31, 2'b01, 1'b0, lat, res);
        checks++; if (res !== 32'h0000_0001) begin failures++; $display("FAIL srl31_result got=%h exp=00000001", res); end
        consume();
    endtask

    task automatic test_special();
        int lat;
        logic [31:0] res;
        do_op(32'hF000_0000, 5'd4, 2'b01, 1'b0, lat, res);
        checks++; if (lat !== exp_lat(4, 1)) begin failures++; $display("FAIL srl4_latency got=%0d exp=%0d", lat, exp_lat(4, 1)); end
        checks++; if (res !== 32'h0F00_0000) begin failures++; $display("FAIL srl4_result got=%h exp=0f000000", res); end
        consume();
        do_op(32'hDEAD_BEEF, 5'd0, 2'b10, 1'b0, lat, res);
        checks++; if (lat !== 1) begin failures++; $display("FAIL shamt0_latency got=%0d exp=1", lat); end
        checks++; if (res !== 32'hDEAD_BEEF) begin failures++; $display("FAIL shamt0_result got=%h exp=deadbeef", res); end
        consume();
        do_op(32'h1234_5678, 5'd7, 2'b11, 1'b0, lat, res);
        checks++; if (lat !== 1) begin failures++; $display("FAIL type11_latency got=%0d exp=1", lat); end
        checks++; if (res !== 32'h0) begin failures++; $display("FAIL type11_result got=%h exp=00000000", res); end
        consume();
    endtask

    task automatic test_backpressure();
        int lat;
        logic [31:0] res;
        do_op(32'hC000_0000, 5'd2, 2'b10, 1'b0, lat, res);
        checks++; if (lat !== exp_lat(2, 2)) begin failures++; $display("FAIL bp_latency got=%0d exp=%0d", lat, exp_lat(2, 2)); end
        checks++; if (res !== 32'hF000_0000) begin failures++; $display("FAIL bp_result got=%h exp=f0000000", res); end
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a        = 32'h0000_0003 + 32'(i);
            shamt    = 5'd1;
            op_type  = 2'b00;
            tick();
            in_valid = 1'b0;
            checks++; if (out_valid !== 1'b1 || r !== 32'hF000_0000 || in_ready !== 1'b0) begin
                failures++; $display("FAIL bp_hold%0d out_valid=%b r=%h in_ready=%b exp 1/f0000000/0", i, out_valid, r, in_ready);
            end
        end
        consume();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL bp_release in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid); end
        tick();
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL bp_no_phantom busy=%b out_valid=%b exp 0/0", busy, out_valid); end
    endtask

    task automatic test_reset_midop();
        int lat;
        logic [31:0] res;
        a        = 32'h0000_0001;
        shamt    = 5'd20;
        op_type  = 2'b00;
        in_valid = 1'b1;
        tick();                       // accept edge N, now in N+1
        in_valid = 1'b0;
        checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL midop_busy busy=%b in_ready=%b exp 1/0", busy, in_ready); end
        for (int i = 0; i < 4; i++) tick();   // now in N+5
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0 || r !== 32'h0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL midop_reset out_valid=%b r=%h in_ready=%b busy=%b exp 0/00000000/1/0", out_valid, r, in_ready, busy);
        end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midop_aborted out_valid=%b exp 0", out_valid); end
        do_op(32'h0000_0001, 5'd3, 2'b00, 1'b0, lat, res);
        checks++; if (lat !== 4) begin failures++; $display("FAIL post_reset_latency got=%0d exp=4", lat); end
        checks++; if (res !== 32'h0000_0008) begin failures++; $display("FAIL post_reset_result got=%h exp=00000008", res); end
        consume();
    endtask

    task automatic test_random();
        int lat;
        logic [31:0] res;
        logic [31:0] ai;
        logic [4:0]  si;
        logic [1:0]  ti;
        logic [31:0] expv;
        int          stall;
        for (int n = 0; n < 1000; n++) begin
            ai = $urandom;
            si = 5'($urandom);
            ti = 2'($urandom);
            case (ti)
                2'b00:   expv = ai << si;
                2'b01:   expv = ai >> si;
                2'b10:   expv = 32'($signed(ai) >>> si);
                default: expv = 32'h0;
            endcase
            do_op(ai, si, ti, 1'b1, lat, res);
            checks++; if (lat !== exp_lat(int'(si), int'(ti)) || res !== expv) begin
                failures++; $display("FAIL rand%0d a=%h sh=%0d ty=%0d got r=%h lat=%0d exp r=%h lat=%0d", n, ai, si, ti, res, lat, expv, exp_lat(int'(si), int'(ti)));
            end
            stall = $urandom_range(0, 3);
            for (int s = 0; s < stall; s++) tick();
            checks++; if (out_valid !== 1'b1 || r !== expv) begin
                failures++; $display("FAIL rand%0d_stall out_valid=%b r=%h exp 1/%h", n, out_valid, r, expv);
            end
            consume();
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        shamt     = '0;
        op_type   = '0;
        test_reset();
        test_sll_basic();
        test_max_shift();
        test_special();
        test_backpressure();
        test_reset_midop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
